// File: rtl/fifo_enq_arbiter_pkg.sv
// fifo_arb_types: shared sizing for the FIFO enqueue arbiter.
//   width_p   : data word width (matches the FIFO word width)
//   num_req_p : number of producers sharing the enqueue port (power of two, >= 2)
//   cnt_w_p   : width of each per-requester grant counter
// The modules take these values as parameter defaults so a single instance can
// still be resized without editing this package.
package fifo_arb_types;

    localparam int width_p   = 8;
    localparam int num_req_p = 4;
    localparam int cnt_w_p   = 16;

    typedef logic [width_p-1:0]            word_t;
    typedef logic [$clog2(num_req_p)-1:0]  req_id_t;
    typedef logic [cnt_w_p-1:0]            cnt_t;

endpackage

// File: rtl/fifo_enq_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority search.
//   valid  : one bit per requester
//   rr_ptr : requester with highest priority this cycle
//   found  : at least one requester is valid
//   winner : first valid requester scanning rr_ptr, rr_ptr+1, ... (mod num_req_p)
module rr_picker #(
    parameter int num_req_p = fifo_arb_types::num_req_p
) (
    input  logic [num_req_p-1:0]          valid,
    input  logic [$clog2(num_req_p)-1:0]  rr_ptr,
    output logic                          found,
    output logic [$clog2(num_req_p)-1:0]  winner
);

    localparam int id_w = $clog2(num_req_p);

    logic [id_w-1:0] idx;

    // Scan from the farthest offset down to offset 0 so the closest valid
    // requester to rr_ptr is the last assignment and therefore wins. The
    // index wraps for free because num_req_p is a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = rr_ptr + id_w'(k);
            if (valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter feeding the single FIFO enqueue port.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid_i   : per-requester "has a word"
//   req_data_i    : per-requester word, requester i in bits [i*width_p +: width_p]
//   req_ready_o   : one-hot (or zero) acceptance of the winning requester
//   enq_valid_o   : output stage holds a word for the FIFO
//   enq_data_o    : word offered to the FIFO
//   enq_ready_i   : FIFO can take a word
//   grant_id_o    : requester that owns the word in the output stage
//   grant_cnt_o   : saturating accepted-word count, requester i in [i*cnt_w_p +: cnt_w_p]
//   clr_cnt_i     : clear all grant counters (wins over a same-cycle grant)
//
// Handshakes: a word moves on a rising edge exactly when valid and ready are
// both high in the cycle before it. On the requester side req_ready_o is a
// combinational function of all valids, the pointer, the stage state and
// enq_ready_i, so requesters must never gate valid on ready. On the FIFO side
// enq_valid_o is registered and the word drains when enq_ready_i is high.
module fifo_enq_arbiter #(
    parameter int width_p   = fifo_arb_types::width_p,
    parameter int num_req_p = fifo_arb_types::num_req_p,
    parameter int cnt_w_p   = fifo_arb_types::cnt_w_p
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_req_p-1:0]           req_valid_i,
    input  logic [num_req_p*width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           enq_valid_o,
    output logic [width_p-1:0]             enq_data_o,
    input  logic                           enq_ready_i,
    output logic [$clog2(num_req_p)-1:0]   grant_id_o,
    output logic [num_req_p*cnt_w_p-1:0]   grant_cnt_o,
    input  logic                           clr_cnt_i
);

    localparam int id_w = $clog2(num_req_p);

    logic                 full;
    logic [width_p-1:0]   data_q;
    logic [id_w-1:0]      id_q;
    logic [id_w-1:0]      rr_ptr;
    logic [cnt_w_p-1:0]   cnt_q [num_req_p];

    logic [width_p-1:0]   word_in [num_req_p];
    logic                 found;
    logic [id_w-1:0]      winner;
    logic                 can_accept;
    logic                 transfer;
    logic                 drain;

    for (genvar g = 0; g < num_req_p; g++) begin : g_lanes
        assign word_in[g] = req_data_i[g*width_p +: width_p];
        assign grant_cnt_o[g*cnt_w_p +: cnt_w_p] = cnt_q[g];
    end

    rr_picker #(
        .num_req_p (num_req_p)
    ) u_picker (
        .valid  (req_valid_i),
        .rr_ptr (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // The stage can load when empty or when its current word leaves on the
    // same edge. Nothing is granted while reset is asserted.
    assign can_accept = !full || enq_ready_i;
    assign transfer   = found && can_accept && !rst;
    assign drain      = full && enq_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (transfer) begin
                // Also covers drain+load in one cycle: the new word replaces the old.
                full   <= 1'b1;
                data_q <= word_in[winner];
                id_q   <= winner;
                rr_ptr <= winner + 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end

            for (int i = 0; i < num_req_p; i++) begin
                if (clr_cnt_i) begin
                    cnt_q[i] <= '0;
                end else if (transfer && winner == id_w'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign enq_valid_o = full;
    assign enq_data_o  = data_q;
    assign grant_id_o  = id_q;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
module tb_fifo_enq_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 10;  // narrow counters so saturation is reached in ~1k grants
  localparam int IW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic              enq_valid;
  logic [W-1:0]      enq_data;
  logic              enq_ready;
  logic [IW-1:0]     grant_id;
  logic [N*CW-1:0]   grant_cnt;
  logic              clr_cnt;

  always #5 clk = ~clk;

  fifo_enq_arbiter #(
    .width_p   (W),
    .num_req_p (N),
    .cnt_w_p   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .enq_valid_o (enq_valid),
    .enq_data_o  (enq_data),
    .enq_ready_i (enq_ready),
    .grant_id_o  (grant_id),
    .grant_cnt_o (grant_cnt),
    .clr_cnt_i   (clr_cnt)
  );

  // ---------------- bench state ----------------
  logic [N-1:0]      cur_valid;
  logic [W-1:0]      word [N];
  int                sent [N];

  // reference model: priority start, stage occupancy, counters, waits
  int                m_ptr;
  bit                m_full;
  int                m_cnt [N];
  int                wait_cnt [N];

  logic [IW+W-1:0]   exp_q [$];
  logic [IW+W-1:0]   exp_word;

  logic [N-1:0]      last_ready;
  logic [CW-1:0]     last_cnt [N];

  int                vectors = 0;
  int                miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // One clock cycle: apply inputs after the edge, sample settled outputs,
  // compare to the model, then advance the model across the next edge.
  task automatic step(input bit r, input bit rdy, input bit clr, output int won);
    logic [N-1:0]    exp_ready;
    logic [N*CW-1:0] exp_cnt;
    @(posedge clk);
    #1;
    rst       = r;
    enq_ready = rdy;
    clr_cnt   = clr;
    req_valid = cur_valid;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word[i];
    #3;

    won = -1;
    if (!r && (!m_full || rdy)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (cur_valid[j]) begin
          won = j;
          break;
        end
      end
    end
    exp_ready = '0;
    if (won >= 0) exp_ready[won] = 1'b1;
    for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);

    last_ready = req_ready;
    for (int i = 0; i < N; i++) last_cnt[i] = grant_cnt[i*CW +: CW];

    check("req_ready", req_ready, exp_ready);
    check("enq_valid", enq_valid, m_full);
    check("grant_cnt", grant_cnt, exp_cnt);

    if (r) begin
      m_full = 0;
      m_ptr  = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        m_cnt[i]    = 0;
        wait_cnt[i] = 0;
      end
    end else begin
      if (won >= 0) begin
        exp_q.push_back({IW'(won), word[won]});
        for (int i = 0; i < N; i++) if (i != won && cur_valid[i]) wait_cnt[i]++;
        vectors++;
        if (wait_cnt[won] > N) begin
          miscompares++;
          $display("FAIL wait_bound: requester %0d waited %0d transfers, limit %0d", won, wait_cnt[won], N);
        end
        wait_cnt[won] = 0;
        m_full = 1;
        m_ptr  = (won + 1) % N;
        if (m_cnt[won] < (1 << CW) - 1) m_cnt[won]++;
      end else if (m_full && rdy) begin
        m_full = 0;
      end
      if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && enq_valid === 1'b1 && enq_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL drain: got id %0d data %0h, expected no word", grant_id, enq_data);
      end else begin
        exp_word = exp_q.pop_front();
        if ({grant_id, enq_data} !== exp_word) begin
          miscompares++;
          $display("FAIL drain: got id %0d data %0h, expected id %0d data %0h",
                   grant_id, enq_data, exp_word[IW+W-1:W], exp_word[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int won;
    rst = 1'b1; enq_ready = 1'b0; clr_cnt = 1'b0; req_valid = '0; req_data = '0;
    m_ptr = 0; m_full = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; wait_cnt[i] = 0; sent[i] = 0;
      word[i] = W'(8'h10 * i);
    end
    cur_valid = '1;

    // reset with every requester valid
    for (int c = 0; c < 3; c++) step(1, 1, 0, won);
    check("reset_data", enq_data, 0);
    check("reset_id", grant_id, 0);

    // full contention, 12 grants in strict rotation
    for (int c = 0; c < 12; c++) begin
      step(0, 1, 0, won);
      check("contention_order", last_ready, 4'b0001 << (c % 4));
      if (won >= 0) begin
        sent[won]++;
        word[won] = W'(8'h10 * won + sent[won]);
      end
    end

    // backpressure: capture a word from requester 2, then stall 5 cycles
    cur_valid = 4'b0100;
    word[2]   = 8'h2C;
    step(0, 1, 0, won);
    for (int i = 0; i < N; i++) check("contention_cnt", last_cnt[i], 3);
    check("bp_capture", last_ready, 4'b0100);
    cur_valid = 4'b1000;
    word[3]   = 8'h3A;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, won);
      check("bp_ready", last_ready, 0);
      check("bp_data", enq_data, 8'h2C);
      check("bp_id", grant_id, 2);
    end
    step(0, 1, 0, won);
    check("bp_release", last_ready, 4'b1000);

    // pointer wrap with sparse requests
    cur_valid = 4'b1000;
    word[3]   = 8'h3B;
    step(0, 1, 0, won);
    check("wrap_first3", last_ready, 4'b1000);
    cur_valid = 4'b1001;
    word[3]   = 8'h3C;
    word[0]   = 8'h0D;
    step(0, 1, 0, won);
    check("wrap_then0", last_ready, 4'b0001);
    cur_valid = 4'b1000;
    step(0, 1, 0, won);
    check("wrap_then3", last_ready, 4'b1000);
    cur_valid = '0;
    step(0, 1, 0, won);

    // counter saturation on requester 1
    cur_valid = 4'b0010;
    for (int c = 0; c < (1 << CW) + 4; c++) begin
      step(0, 1, 0, won);
      if (won >= 0) word[won] = W'($urandom);
    end
    check("cnt_saturate", last_cnt[1], (1 << CW) - 1);

    // clear in the same cycle as a grant to requester 1
    step(0, 1, 1, won);
    check("clr_grant", last_ready, 4'b0010);
    cur_valid = '0;
    step(0, 1, 0, won);
    check("clr_wins", last_cnt[1], 0);

    // random soak with one reset in the middle
    for (int c = 0; c < 10000; c++) begin
      step(c == 5000, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0, won);
      if (won >= 0) cur_valid[won] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!cur_valid[i] && $urandom_range(0, 1) == 1) begin
          cur_valid[i] = 1'b1;
          word[i]      = W'($urandom);
        end
      end
    end

    // drain and confirm nothing was lost
    cur_valid = '0;
    for (int c = 0; c < 4; c++) step(0, 1, 0, won);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Round-robin arbiter that shares the single enqueue port of the mp1 FIFO among `num_req_p` producers. It picks one valid requester per cycle, captures its word in a registered output stage and presents it to the FIFO with a valid/ready handshake. Per-requester saturating grant counters feed fairness checks in the bench and the grader.

## Interface
- `width_p`, default 8: data word width, equal to the FIFO word width.
- `num_req_p`, default 4: number of requesters; power of two, at least 2.
- `cnt_w_p`, default 16: grant counter width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid_i`  in  num_req_p: requester i has a word.
- `req_data_i`  in  num_req_p × width_p: word from each requester.
- `req_ready_o`  out  num_req_p: one-hot or zero; word i is accepted this cycle.
- `enq_valid_o`  out  1: output stage holds a word for the FIFO.
- `enq_data_o`  out  width_p: word offered to the FIFO.
- `enq_ready_i`  in  1: FIFO can accept a word (not full).
- `grant_id_o`  out  log2(num_req_p): requester that owns the current output word.
- `grant_cnt_o`  out  num_req_p × cnt_w_p: accepted-word count per requester.
- `clr_cnt_i`  in  1: synchronous clear of all grant counters.

## Operation
- State:
  - output register `{full, data, id}`;
  - round-robin pointer `rr_ptr` (log2(num_req_p) bits);
  - grant counters.
- Acceptance:
  - `can_accept = !full || enq_ready_i`.
  - This gives one word per cycle when the FIFO is never full.
- Winner selection:
  - The winner is the first i with `req_valid_i[i]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo `num_req_p`.
  - If no requester is valid there is no winner.
- Ready and capture:
  - `req_ready_o[winner] = can_accept`; all other ready bits are 0.
  - A transfer occurs when the winner is valid and ready.
  - On transfer: `data <= req_data_i[winner]`, `id <= winner`, `full <= 1`, `rr_ptr <= winner+1` (wraps to 0 after `num_req_p-1`).
- Drain:
  - A drain occurs when `enq_valid_o && enq_ready_i`.
  - Drain without transfer: `full <= 0`.
  - Drain and transfer in the same cycle: `full` stays 1 and the new word replaces the old.
- Pointer and data hold:
  - `rr_ptr` holds when there is no transfer.
  - `data` and `id` hold while `full && !enq_ready_i`.
- Grant counters:
  - `grant_cnt_o[i]` increments on each transfer from i and saturates at all-ones.
  - `clr_cnt_i` sets all counters to 0. It takes priority over a same-cycle increment, so that grant is not counted.
- Requester-side rules (the arbiter does not check these):
  - A requester holds its valid and data stable until accepted.
  - `req_ready_o` depends combinationally on other requesters' valids, so a requester must not gate its valid on ready.

## Timing
- Reset values:
  - `enq_valid_o=0`, `enq_data_o=0`, `grant_id_o=0`, `rr_ptr=0`;
  - all `grant_cnt_o=0`;
  - `req_ready_o` is 0 in the reset cycle, forced regardless of valids.
- Latency: a word accepted at edge t appears on `enq_valid_o`/`enq_data_o` after edge t, i.e. one cycle.
- Throughput:
  - One word per cycle while `enq_ready_i` stays high.
  - `enq_ready_i` combinationally affects `req_ready_o`; this path is intentional.
- Stall: while `enq_ready_i=0` and `full=1`:
  - all `req_ready_o` are 0;
  - the outputs stay bit-stable.
- Reset mid-operation:
  - the word in the output stage is dropped;
  - no requester is granted in the reset cycle;
  - the pointer returns to 0.
- Fairness bound: with all requesters continuously valid and the FIFO never full, each requester is granted exactly once per `num_req_p` consecutive transfers.
- Outputs: all outputs except `req_ready_o` are driven directly from registers.

## Structure
- Package `fifo_arb_types` holds:
  - `width_p`, `num_req_p`, `cnt_w_p`;
  - `typedef logic [width_p-1:0] word_t`;
  - `typedef logic [$clog2(num_req_p)-1:0] req_id_t`;
  - `typedef logic [cnt_w_p-1:0] cnt_t`.
- Sub-module `rr_picker`:
  - purely combinational rotating-priority search;
  - inputs: valid vector, `rr_ptr`;
  - outputs: `found`, `winner`.
- Top level: the output register, `rr_ptr`, the counters and the handshake glue.

## Test plan
- **Reset behaviour:**
  - Stimulus: reset with all `req_valid_i=1`.
  - Required: `req_ready_o=0000`, `enq_valid_o=0`, counters 0.
  - Then: first grant after release goes to requester 0.
- **Full contention:**
  - Stimulus: 4 requesters always valid (data = `8'h10*i + n`), `enq_ready_i=1`, 12 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3,0,1,2,3.
  - Required: every `grant_cnt_o[i]=3`.
- **Backpressure:**
  - Stimulus: hold `enq_ready_i=0` for 5 cycles after a word from requester 2 is captured.
  - Required: `enq_data_o` and `grant_id_o=2` stable, all ready bits 0.
  - Required: on release the word drains and requester 3 is granted in the same cycle.
- **Pointer wrap and sparse requests:**
  - Stimulus: only requester 3 valid, then only requesters 0 and 3 valid.
  - Required: 3 is granted, then 0 (pointer wrapped), then 3.
- **Counter edge cases:**
  - Stimulus: preload near saturation by forcing or a long run.
  - Required: counter sticks at `16'hFFFF`.
  - Stimulus: `clr_cnt_i` in the same cycle as a grant to 1.
  - Required: `grant_cnt_o[1]=0` next cycle.
- **Random soak with scoreboard:**
  - Stimulus: random valids and random `enq_ready_i` for 10000 cycles.
  - Required: each requester's words reach the FIFO in order, with no loss or duplication.
  - Required: no requester waits more than `num_req_p` transfers while valid.
